icache_ctrl: RTL and testbench

Direct-mapped instruction cache controller between `inst_fetch` and the memory port. It serves the fetch-group address (`core2icache_addr`) combinationally on a hit and returns four 32-bit instructions on `icache2core_data`. On a miss it sequences a four-beat line refill from memory through a valid/ready request channel. It also owns whole-cache invalidation for `fence.i`.

---
 rtl/icache_ctrl_if.sv | 37 +++
 rtl/icache_ctrl.sv | 158 +++++++++++++++
 tb/tb_icache_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signal bundle for icache_ctrl.
// The hit_count/miss_count counters exist only when ICACHE_STATS_EN is defined.
interface icache_ctrl_if;
  logic [31:0]  core2icache_addr;
  logic         icache_flush;
  logic [127:0] icache2core_data;
  logic         icache2core_data_valid;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  modport slave (
    input  core2icache_addr, icache_flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output icache2core_data, icache2core_data_valid, mem_req_valid, mem_req_addr,
    output hit_count, miss_count
  );
  modport master (
    output core2icache_addr, icache_flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  icache2core_data, icache2core_data_valid, mem_req_valid, mem_req_addr,
    input  hit_count, miss_count
  );
`else
  modport slave (
    input  core2icache_addr, icache_flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output icache2core_data, icache2core_data_valid, mem_req_valid, mem_req_addr
  );
  modport master (
    output core2icache_addr, icache_flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  icache2core_data, icache2core_data_valid, mem_req_valid, mem_req_addr
  );
`endif
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, 4-beat line refill, fence.i flush.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_ctrl #(
  parameter int NUM_SETS = 64
) (
  input  logic         clock,
  input  logic         reset,
  icache_ctrl_if.slave bus
);

  localparam int          IDX_W = $clog2(NUM_SETS);
  localparam int          TAG_W = 28 - IDX_W;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t               state_r;
  logic [NUM_SETS-1:0]  valid_r;
  logic [TAG_W-1:0]     tag_r  [NUM_SETS];
  logic [127:0]         data_r [NUM_SETS];
  logic [31:0]          req_addr_r;
  logic                 req_valid_r;
  logic [1:0]           beat_r;
  logic [95:0]          beat_buf_r;
  logic                 flush_pend_r;

  logic [IDX_W-1:0]     idx_s;
  logic [TAG_W-1:0]     tag_s;
  logic [1:0]           off_s;
  logic [127:0]         line_s;
  logic [127:0]         shifted_s;
  logic [127:0]         rd_data_s;
  logic                 hit_s;
  logic [IDX_W-1:0]     fill_idx_s;
  logic [TAG_W-1:0]     fill_tag_s;
  logic                 unused_addr_bits_s;

  assign idx_s              = bus.core2icache_addr[4 +: IDX_W];
  assign tag_s              = bus.core2icache_addr[31 -: TAG_W];
  assign off_s              = bus.core2icache_addr[3:2];
  assign fill_idx_s         = req_addr_r[4 +: IDX_W];
  assign fill_tag_s         = req_addr_r[31 -: TAG_W];
  assign unused_addr_bits_s = ^bus.core2icache_addr[1:0];

  // Tag lookup against the current fetch address
  always_comb begin
    hit_s = (state_r == IDLE) && valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  end

  // Align the line to the fetch offset; slots past the line end become NOPs
  always_comb begin
    line_s    = data_r[idx_s];
    shifted_s = line_s >> {off_s, 5'd0};
    rd_data_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (({1'b0, off_s} + 3'(i)) <= 3'd3) begin
        rd_data_s[32*i +: 32] = shifted_s[32*i +: 32];
      end else begin
        rd_data_s[32*i +: 32] = NOP_INSN;
      end
    end
  end

  assign bus.icache2core_data       = rd_data_s;
  assign bus.icache2core_data_valid = hit_s;
  assign bus.mem_req_valid          = req_valid_r;
  assign bus.mem_req_addr           = req_addr_r;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  assign bus.hit_count  = hit_cnt_r;
  assign bus.miss_count = miss_cnt_r;
`endif

  // Controller FSM, valid/tag/data arrays and refill sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      beat_r       <= 2'd0;
      req_valid_r  <= 1'b0;
      req_addr_r   <= 32'd0;
      beat_buf_r   <= '0;
      flush_pend_r <= 1'b0;
`ifdef ICACHE_STATS_EN
      hit_cnt_r    <= 32'd0;
      miss_cnt_r   <= 32'd0;
`endif
    end else begin
      if (bus.icache_flush) begin
        valid_r <= '0;
      end
`ifdef ICACHE_STATS_EN
      if (hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
`endif
      case (state_r)
        IDLE: begin
          flush_pend_r <= 1'b0;
          if (!hit_s) begin
            req_addr_r  <= {bus.core2icache_addr[31:4], 4'd0};
            req_valid_r <= 1'b1;
            state_r     <= REQ;
`ifdef ICACHE_STATS_EN
            if (miss_cnt_r != 32'hFFFF_FFFF) begin
              miss_cnt_r <= miss_cnt_r + 32'd1;
            end
`endif
          end
        end
        REQ: begin
          if (bus.icache_flush) begin
            flush_pend_r <= 1'b1;
          end
          if (bus.mem_req_ready) begin
            req_valid_r <= 1'b0;
            beat_r      <= 2'd0;
            state_r     <= REFILL;
          end
        end
        REFILL: begin
          if (bus.icache_flush) begin
            flush_pend_r <= 1'b1;
          end
          if (bus.mem_resp_valid) begin
            beat_r <= beat_r + 2'd1;
            case (beat_r)
              2'd0: beat_buf_r[31:0]  <= bus.mem_resp_data;
              2'd1: beat_buf_r[63:32] <= bus.mem_resp_data;
              2'd2: beat_buf_r[95:64] <= bus.mem_resp_data;
              2'd3: begin
                // A flush seen at any point of this refill leaves the line invalid
                data_r[fill_idx_s]  <= {bus.mem_resp_data, beat_buf_r};
                tag_r[fill_idx_s]   <= fill_tag_s;
                valid_r[fill_idx_s] <= ~(flush_pend_r | bus.icache_flush);
                flush_pend_r        <= 1'b0;
                state_r             <= IDLE;
              end
              default: ;
            endcase
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: refill requests and expected lines are queued as misses are provoked.
module tb_icache_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  icache_ctrl_if bus ();

  icache_ctrl #(.NUM_SETS(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
  } req_t;

  req_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_miss = 0;

  localparam logic [127:0] LA = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] LC = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
  localparam logic [127:0] LD = 128'hD4000003_D4000002_D4000001_D4000000;
  localparam logic [127:0] LE = 128'hE5000003_E5000002_E5000001_E5000000;
  localparam logic [127:0] LF = 128'hF6000003_F6000002_F6000001_F6000000;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] view(input logic [127:0] line, input int off);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      if (i + off <= 3) r[32*i +: 32] = line[32*(i+off) +: 32];
      else              r[32*i +: 32] = 32'h0000_0013;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic expect_miss(input logic [31:0] line_addr, input logic [127:0] line);
    req_t it;
    #1;
    chk("miss_valid", bus.icache2core_data_valid, 1'b0);
    it.addr = line_addr;
    it.line = line;
    exp_q.push_back(it);
    exp_miss++;
  endtask

  task automatic expect_hit(input logic [127:0] line, input int off);
    #1;
    chk("hit_valid", bus.icache2core_data_valid, 1'b1);
    chk("hit_data", bus.icache2core_data, view(line, off));
  endtask

  // flush_mode: 0..3 flush on that beat, 4 flush in a gap after the second beat, -1 none
  task automatic serve(input int stall, input logic [31:0] redirect, input int flush_mode);
    req_t it;
    it = exp_q.pop_front();
    tick();
    for (int s = 0; s < stall; s++) begin
      bus.mem_req_ready = 1'b0;
      if (s == 0 && redirect != 32'd0) bus.core2icache_addr = redirect;
      #1;
      chk("stall_req_valid", bus.mem_req_valid, 1'b1);
      chk("stall_req_addr", bus.mem_req_addr, it.addr);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    chk("req_valid", bus.mem_req_valid, 1'b1);
    chk("req_addr", bus.mem_req_addr, it.addr);
    tick();
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = it.line[32*k +: 32];
      bus.icache_flush   = (flush_mode == k);
      #1;
      chk("refill_busy", bus.icache2core_data_valid, 1'b0);
      chk("req_dropped", bus.mem_req_valid, 1'b0);
      tick();
      bus.icache_flush = 1'b0;
      if (k == 1 && flush_mode == 4) begin
        bus.mem_resp_valid = 1'b0;
        bus.icache_flush   = 1'b1;
        tick();
        bus.icache_flush = 1'b0;
      end
    end
    bus.mem_resp_valid = 1'b0;
`ifdef ICACHE_STATS_EN
    #1;
    chk("miss_count", bus.miss_count, 32'(exp_miss));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                 = 1'b1;
    bus.core2icache_addr  = 32'h1000;
    bus.icache_flush      = 1'b0;
    bus.mem_req_ready     = 1'b0;
    bus.mem_resp_valid    = 1'b0;
    bus.mem_resp_data     = 32'd0;
    tick();
    tick();
    #1;
    chk("rst_data_valid", bus.icache2core_data_valid, 1'b0);
    chk("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_req_addr", bus.mem_req_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", bus.hit_count, 32'd0);
    chk("rst_miss_count", bus.miss_count, 32'd0);
`endif
    reset = 1'b0;

    // Cold miss: hit must appear exactly six cycles after the miss cycle
    expect_miss(32'h1000, LA);
    serve(0, 32'd0, -1);
    expect_hit(LA, 0);
    bus.core2icache_addr = 32'h1008;
    expect_hit(LA, 2);
    chk("hit_1008_const", bus.icache2core_data, 128'h00000013_00000013_00000044_00000033);
    bus.core2icache_addr = 32'h1004;
    expect_hit(LA, 1);
    tick();

    // Conflict eviction in set 0
    bus.core2icache_addr = 32'h1400;
    expect_miss(32'h1400, LB);
    serve(0, 32'd0, -1);
    expect_hit(LB, 0);
    tick();
    bus.core2icache_addr = 32'h1000;
    expect_miss(32'h1000, LA);
    serve(0, 32'd0, -1);
    expect_hit(LA, 0);
    tick();

    // Flush in a gap after the second beat: refill completes but the line stays invalid
    bus.core2icache_addr = 32'h301C;
    expect_miss(32'h3010, LD);
    serve(0, 32'd0, 4);
    expect_miss(32'h3010, LD);
    serve(0, 32'd0, -1);
    expect_hit(LD, 3);
    tick();

    // Flush on the same edge as the final beat
    bus.core2icache_addr = 32'h3020;
    expect_miss(32'h3020, LE);
    serve(0, 32'd0, 3);
    expect_miss(32'h3020, LE);
    serve(0, 32'd0, -1);
    expect_hit(LE, 0);
    tick();

    // Stalled request with a redirect: 0x1000 completes, then 0x2000 misses
    bus.core2icache_addr = 32'h1000;
    expect_miss(32'h1000, LA);
    serve(5, 32'h2000, -1);
    expect_miss(32'h2000, LC);
    serve(0, 32'd0, -1);
    expect_hit(LC, 0);
    tick();

    // Reset after the third beat discards the partial line
    bus.core2icache_addr = 32'h4000;
    #1;
    chk("rmiss_valid", bus.icache2core_data_valid, 1'b0);
    exp_miss++;
    tick();
    bus.mem_req_ready = 1'b1;
    #1;
    chk("rmiss_req_addr", bus.mem_req_addr, 32'h4000);
    tick();
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hBAD0_0000 + 32'(k);
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    reset = 1'b1;
    tick();
    #1;
    chk("mid_rst_req_valid", bus.mem_req_valid, 1'b0);
    chk("mid_rst_data_valid", bus.icache2core_data_valid, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("mid_rst_miss_count", bus.miss_count, 32'd0);
`endif
    exp_miss = 0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    reset = 1'b0;
    expect_miss(32'h4000, LF);
    serve(0, 32'd0, -1);
    expect_hit(LF, 0);
`ifdef ICACHE_STATS_EN
    chk("hit_count_before", bus.hit_count, 32'd0);
    tick();
    #1;
    chk("hit_count_after", bus.hit_count, 32'd1);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
